// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the canonical NOP and the instruction-fetch FSM encoding.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [1:0] if_state_t;

  localparam if_state_t S_BOOT    = 2'd0;
  localparam if_state_t S_FETCH   = 2'd1;
  localparam if_state_t S_DISCARD = 2'd2;

endpackage

// File: rtl/pc_reg.sv
// Program counter with +4 incrementer and branch redirect mux.
// Redirect beats hold, and hold beats advance.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_sel,
  input  logic [31:0] branch_target,
  input  logic        hold,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // NOTE: assign a default first so that no path through the block leaves pc_next unassigned (that would infer a latch).
  always_comb begin
    pc_next = pc;
    if (branch_sel)
      pc_next = branch_target;
    else if (!hold && advance)
      pc_next = pc + 32'd4;  // 32-bit add wraps 0xFFFF_FFFC to 0
  end

  // NOTE: non-blocking assignment for registered state, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

endmodule

// File: rtl/if_unit.sv
// Instruction-fetch stage: fetch FSM, PC (via pc_reg) and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the FETCH_STALL_CNT / FLUSH_CNT performance counters.
module if_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_SEL,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        IFID_HOLD,
  input  logic        IFID_RESET,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC_IF,
  output logic [31:0] INSTRUCTION_IFID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);

  if_state_t   state, state_next;
  logic [31:0] pc;
  logic        accept;

  assign IMEM_READ = (state != S_BOOT);
  assign IMEM_ADDR = pc;
  assign accept    = (state == S_FETCH) && !IMEM_BUSYWAIT;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (CLK),
    .rst           (RESET),
    .branch_sel    (BRANCH_SEL),
    .branch_target (BRANCH_TARGET),
    .hold          (IFID_HOLD),
    .advance       (accept),
    .pc            (pc)
  );

  // A redirect that lands while a fetch is still pending must throw away that late response.
  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:    state_next = S_FETCH;
      S_FETCH:   if (BRANCH_SEL && IMEM_BUSYWAIT) state_next = S_DISCARD;
      S_DISCARD: if (!(BRANCH_SEL && IMEM_BUSYWAIT) && !IMEM_BUSYWAIT) state_next = S_FETCH;
      default:   state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_BOOT;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC_IF            <= 32'd0;
      INSTRUCTION_IFID <= NOP_INSTR;
    end else if (BRANCH_SEL) begin
      PC_IF            <= 32'd0;
      INSTRUCTION_IFID <= NOP_INSTR;
    end else if (IFID_HOLD) begin
      PC_IF            <= PC_IF;
      INSTRUCTION_IFID <= INSTRUCTION_IFID;
    end else if (accept && !IFID_RESET) begin
      PC_IF            <= pc;
      INSTRUCTION_IFID <= IMEM_INSTR;
    end else begin
      PC_IF            <= 32'd0;
      INSTRUCTION_IFID <= NOP_INSTR;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Both counters saturate instead of wrapping.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FETCH_STALL_CNT <= 32'd0;
      FLUSH_CNT       <= 32'd0;
    end else begin
      if ((state != S_BOOT) && IMEM_BUSYWAIT && (FETCH_STALL_CNT != 32'hFFFF_FFFF))
        FETCH_STALL_CNT <= FETCH_STALL_CNT + 32'd1;
      if (BRANCH_SEL && (FLUSH_CNT != 32'hFFFF_FFFF))
        FLUSH_CNT <= FLUSH_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_unit.sv
// Directed self-checking bench for if_unit (RESET_PC = 0x100); memory returns addr ^ 0xDEAD_0000 unless overridden.
module tb_if_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BRANCH_SEL;
  logic [31:0] BRANCH_TARGET;
  logic        IFID_HOLD;
  logic        IFID_RESET;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_INSTR;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] PC_IF;
  logic [31:0] INSTRUCTION_IFID;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FETCH_STALL_CNT;
  logic [31:0] FLUSH_CNT;
`endif

  logic        force_en;
  logic [31:0] force_val;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 CLK = ~CLK;

  assign IMEM_INSTR = force_en ? force_val : (IMEM_ADDR ^ 32'hDEAD_0000);

  if_unit #(.RESET_PC(32'h0000_0100)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .BRANCH_SEL       (BRANCH_SEL),
    .BRANCH_TARGET    (BRANCH_TARGET),
    .IFID_HOLD        (IFID_HOLD),
    .IFID_RESET       (IFID_RESET),
    .IMEM_BUSYWAIT    (IMEM_BUSYWAIT),
    .IMEM_INSTR       (IMEM_INSTR),
    .IMEM_READ        (IMEM_READ),
    .IMEM_ADDR        (IMEM_ADDR),
    .PC_IF            (PC_IF),
    .INSTRUCTION_IFID (INSTRUCTION_IFID)
`ifdef IF_PERF_CNT_EN
    ,
    .FETCH_STALL_CNT  (FETCH_STALL_CNT),
    .FLUSH_CNT        (FLUSH_CNT)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_stage(input string tag, input logic [31:0] addr, input logic [31:0] pc_if, input logic [31:0] instr);
    check({tag, " addr"},  IMEM_ADDR,        addr);
    check({tag, " pc_if"}, PC_IF,            pc_if);
    check({tag, " instr"}, INSTRUCTION_IFID, instr);
  endtask

  initial begin
    RESET = 1'b1; BRANCH_SEL = 1'b0; BRANCH_TARGET = 32'd0;
    IFID_HOLD = 1'b0; IFID_RESET = 1'b0; IMEM_BUSYWAIT = 1'b0;
    force_en = 1'b0; force_val = 32'd0;

    // Reset values appear before any clock edge
    #3;
    expect_stage("reset", 32'h100, 32'd0, NOP);
    check("reset read", {31'd0, IMEM_READ}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("reset stall_cnt", FETCH_STALL_CNT, 32'd0);
    check("reset flush_cnt", FLUSH_CNT, 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("boot read", {31'd0, IMEM_READ}, 32'd0);

    // BOOT -> FETCH, then zero-latency fetches 0x100, 0x104, 0x108
    tick; expect_stage("boot->fetch", 32'h100, 32'd0, NOP);
    check("fetch read", {31'd0, IMEM_READ}, 32'd1);
    tick; expect_stage("seq1", 32'h104, 32'h100, 32'hDEAD_0100);
    tick; expect_stage("seq2", 32'h108, 32'h104, 32'hDEAD_0104);

    // Redirect to 0x8 with memory ready
    BRANCH_SEL = 1'b1; BRANCH_TARGET = 32'h8;
    tick; expect_stage("br8", 32'h8, 32'd0, NOP);
    BRANCH_SEL = 1'b0;

    // Three busywait cycles at 0x8 give three bubbles
    IMEM_BUSYWAIT = 1'b1;
    tick; expect_stage("bw1", 32'h8, 32'd0, NOP);
    tick; expect_stage("bw2", 32'h8, 32'd0, NOP);
    tick; expect_stage("bw3", 32'h8, 32'd0, NOP);
    IMEM_BUSYWAIT = 1'b0;
    tick; expect_stage("bw done", 32'hC, 32'h8, 32'hDEAD_0008);
    tick; expect_stage("fetch c", 32'h10, 32'hC, 32'hDEAD_000C);

    // Branch to 0x40 while 0x10 is pending: late 0x10 response is dropped
    IMEM_BUSYWAIT = 1'b1;
    tick; expect_stage("bw10", 32'h10, 32'd0, NOP);
    BRANCH_SEL = 1'b1; BRANCH_TARGET = 32'h40;
    tick; expect_stage("br40", 32'h40, 32'd0, NOP);
    BRANCH_SEL = 1'b0; IMEM_BUSYWAIT = 1'b0;
    force_en = 1'b1; force_val = 32'hDEAD_0010;
    tick; expect_stage("discard", 32'h40, 32'd0, NOP);
    force_en = 1'b0;
    tick; expect_stage("after discard", 32'h44, 32'h40, 32'hDEAD_0040);
`ifdef IF_PERF_CNT_EN
    check("stall_cnt", FETCH_STALL_CNT, 32'd5);
    check("flush_cnt", FLUSH_CNT, 32'd2);
`endif

    // Hold for two cycles with 0x00A00093 in IF/ID
    force_en = 1'b1; force_val = 32'h00A0_0093;
    tick; expect_stage("load addi", 32'h48, 32'h44, 32'h00A0_0093);
    IFID_HOLD = 1'b1;
    tick; expect_stage("hold1", 32'h48, 32'h44, 32'h00A0_0093);
    tick; expect_stage("hold2", 32'h48, 32'h44, 32'h00A0_0093);
    IFID_HOLD = 1'b0; force_en = 1'b0;
    tick; expect_stage("unhold", 32'h4C, 32'h48, 32'hDEAD_0048);

    // IF/ID flush while a response is accepted: bubble, PC still advances
    IFID_RESET = 1'b1;
    tick; expect_stage("ifid_reset", 32'h50, 32'd0, NOP);
    IFID_RESET = 1'b0;

    // PC wrap from 0xFFFF_FFFC
    BRANCH_SEL = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    tick; expect_stage("br top", 32'hFFFF_FFFC, 32'd0, NOP);
    BRANCH_SEL = 1'b0;
    tick; expect_stage("wrap", 32'h0, 32'hFFFF_FFFC, 32'h2152_FFFC);

    // Asynchronous reset in the middle of a pending fetch
    IMEM_BUSYWAIT = 1'b1;
    tick;
    #2 RESET = 1'b1;
    #1;
    expect_stage("mid reset", 32'h100, 32'd0, NOP);
    check("mid reset read", {31'd0, IMEM_READ}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("mid reset stall_cnt", FETCH_STALL_CNT, 32'd0);
    check("mid reset flush_cnt", FLUSH_CNT, 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0; IMEM_BUSYWAIT = 1'b0;
    tick; expect_stage("rst boot", 32'h100, 32'd0, NOP);
    tick; expect_stage("rst first", 32'h104, 32'h100, 32'hDEAD_0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state rises on posedge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port BRANCH_SEL  input  1  redirect request from EX.
REQ-005 SHALL have port BRANCH_TARGET  input  32  redirect address.
REQ-006 SHALL have port IFID_HOLD  input  1  load-use stall from the flush unit.
REQ-007 SHALL have port IFID_RESET  input  1  IF/ID flush from the flush unit.
REQ-008 SHALL have port IMEM_BUSYWAIT  input  1  instruction memory not ready.
REQ-009 SHALL have port IMEM_INSTR  input  32  instruction read data.
REQ-010 SHALL have port IMEM_READ  output  1  fetch request.
REQ-011 SHALL have port IMEM_ADDR  output  32  fetch address, equal to the current PC.
REQ-012 SHALL have port PC_IF  output  32  IF/ID registered PC.
REQ-013 SHALL have port INSTRUCTION_IFID  output  32  IF/ID registered instruction.

Function
REQ-014 SHALL implement FSM states BOOT, FETCH and DISCARD; IMEM_READ=0 in BOOT and 1 otherwise.
REQ-015 SHALL transition BOOT->FETCH unconditionally after one cycle.
REQ-016 SHALL define acceptance as a posedge with state FETCH, IMEM_READ=1, IMEM_BUSYWAIT=0.
REQ-017 SHALL apply update priority RESET > BRANCH_SEL > IFID_HOLD > acceptance > bubble.
REQ-018 SHALL, on acceptance without BRANCH_SEL/IFID_HOLD/IFID_RESET, load IF/ID with {PC, IMEM_INSTR} and set PC <= PC+4 (mod 2^32, wrap from 0xFFFF_FFFC to 0).
REQ-019 SHALL, on BRANCH_SEL, set PC <= BRANCH_TARGET, load INSTRUCTION_IFID with NOP_INSTR and PC_IF with 0, and drop any response arriving that cycle.
REQ-020 SHALL, on BRANCH_SEL while IMEM_BUSYWAIT=1 in FETCH or DISCARD, enter or remain in DISCARD.
REQ-021 SHALL, in DISCARD, drop the next response (IMEM_BUSYWAIT=0), leave the PC unchanged, and return to FETCH.
REQ-022 SHALL, on IFID_HOLD, freeze the PC and the IF/ID register and not advance on a response; the same address is refetched.
REQ-023 SHALL, on IFID_RESET without BRANCH_SEL, load the IF/ID register with {0, NOP_INSTR}; the PC advances only if a response was accepted.
REQ-024 SHALL, on a cycle with no acceptance, no hold and no branch (busywait, BOOT or DISCARD), load a bubble {0, NOP_INSTR} into IF/ID and keep the PC.
REQ-025 SHALL use NOP_INSTR = 32'h0000_0013 (addi x0,x0,0).

Reset
REQ-026 SHALL, on RESET assertion, immediately set PC=RESET_PC, PC_IF=0, INSTRUCTION_IFID=NOP_INSTR, state=BOOT, IMEM_READ=0, independent of CLK.
REQ-027 SHALL, on RESET mid-fetch, abandon the outstanding request; the first request after release is to RESET_PC.

Configuration
REQ-028 SHALL, with IF_PERF_CNT_EN defined, add outputs FETCH_STALL_CNT (32) and FLUSH_CNT (32).
REQ-029 SHALL increment FETCH_STALL_CNT on each FETCH/DISCARD cycle with IMEM_BUSYWAIT=1, and FLUSH_CNT on each BRANCH_SEL cycle; both saturate at 0xFFFF_FFFF and clear on RESET.
REQ-030 SHALL, without IF_PERF_CNT_EN, omit these ports and counters, with all other behaviour identical.

Structure
REQ-031 SHALL place NOP_INSTR and the FSM state typedef in shared package pipeline_pkg.
REQ-032 SHALL implement the PC register, incrementer and redirect mux as sub-module pc_reg; the FSM and IF/ID register stay in if_unit.

Verification
REQ-033 SHALL cover reset with RESET_PC=0x100 and zero-latency memory: IMEM_ADDR sequence 0x100, 0x104, 0x108; PC_IF follows one cycle later.
REQ-034 SHALL cover IMEM_BUSYWAIT high for 3 cycles at PC 0x8: three NOP bubbles, PC held at 0x8, then the instruction at 0x8 is latched.
REQ-035 SHALL cover BRANCH_SEL=1 with BRANCH_TARGET=0x40 during busywait at 0x10: DISCARD entered, the 0x10 response is dropped, and the next latched PC_IF is 0x40.
REQ-036 SHALL cover IFID_HOLD for 2 cycles with instruction 0x00A00093 in IF/ID: outputs are stable for 2 cycles and PC does not advance.
REQ-037 SHALL cover PC=0xFFFF_FFFC accepted: next IMEM_ADDR is 0x0000_0000.
REQ-038 SHALL cover IF_PERF_CNT_EN builds with 5 busywait cycles and 2 branches: FETCH_STALL_CNT=5 and FLUSH_CNT=2.
